sync_fifo_param: RTL and testbench

- Parametrised synchronous FIFO. Next generation of the team's 16x8 FIFO.
- Adds configurable width and depth, true full at DEPTH entries, and simultaneous read+write in one cycle.
- Adds occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer in the same clock domain; drives the testbench scoreboard path through fifo_if-style signals.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 24 ++
 rtl/sync_fifo_param.sv | 131 +++++++++++++
 tb/tb_sync_fifo_param.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the parametrised synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 16;

  // Occupancy must reach DEPTH itself, hence one bit more than the pointers.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH storage array: synchronous write, asynchronous read address, no reset.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, threshold flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEF_WIDTH,
  parameter int DEPTH    = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         re,
  output logic [WIDTH-1:0]             rdata,
  output logic                         rvalid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  fifo_err_t        r_err;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [WIDTH-1:0] w_mem_rdata;

  // Flags decode the registered count only; pointers alone cannot tell full from empty.
  assign w_full       = (r_count == C_DEPTH);
  assign w_empty      = (r_count == '0);
  assign w_wr_ok      = we && !w_full;
  assign w_rd_ok      = re && !w_empty;

  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
  assign count        = r_count;
  assign overflow     = r_err.overflow;
  assign underflow    = r_err.underflow;

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_wr_en (w_wr_ok),
    .i_waddr (r_wptr),
    .i_wdata (wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + CW'(1);
      end else if (!w_wr_ok && w_rd_ok) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= '0;
    end else begin
      if (we && w_full) begin
        r_err.overflow <= 1'b1;
      end else if (clr_err) begin
        r_err.overflow <= 1'b0;
      end
      if (re && w_empty) begin
        r_err.underflow <= 1'b1;
      end else if (clr_err) begin
        r_err.underflow <= 1'b0;
      end
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata  = w_mem_rdata;
  assign rvalid = !w_empty;
`else
  logic [WIDTH-1:0] r_rdata;
  logic             r_rvalid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_rd_ok;
      if (w_rd_ok) begin
        r_rdata <= w_mem_rdata;
      end
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: vector table, directed corner sequences, random vs queue model.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = D - 2;
  localparam int AE = 2;
  localparam int NV = 34;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         we = 1'b0;
  logic         re = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] rdata;
  logic         rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]   count;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] mq[$];
  bit           m_ovf, m_udf, m_rvalid;
  logic [W-1:0] m_rdata;

  typedef struct {
    bit           we, re, clr;
    logic [W-1:0] wdata;
    int           exp_count;
    bit           exp_full, exp_empty, exp_af, exp_ae, exp_ovf, exp_udf, exp_rvalid, chk_rd;
    logic [W-1:0] exp_rd;
  } vec_t;

  vec_t vecs[NV];

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .wdata(wdata), .re(re),
    .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rvalid = 1'b0;
    m_rdata = '0;
  endtask

  task automatic model_step();
    bit           full_m, empty_m, wr_ok, rd_ok;
    logic [W-1:0] popped;
    full_m  = (mq.size() == D);
    empty_m = (mq.size() == 0);
    wr_ok   = we && !full_m;
    rd_ok   = re && !empty_m;
    popped  = '0;
    if (rd_ok) popped = mq.pop_front();
    if (wr_ok) mq.push_back(wdata);
    m_ovf = (we && full_m) ? 1'b1 : (clr_err ? 1'b0 : m_ovf);
    m_udf = (re && empty_m) ? 1'b1 : (clr_err ? 1'b0 : m_udf);
    m_rvalid = rd_ok;
    if (rd_ok) m_rdata = popped;
  endtask

  task automatic apply(input bit w, input bit r, input bit c, input logic [W-1:0] d);
    we = w;
    re = r;
    clr_err = c;
    wdata = d;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = mq.size();
    chk({tag, " count"}, count, n);
    chk({tag, " full"}, full, n == D);
    chk({tag, " empty"}, empty, n == 0);
    chk({tag, " almost_full"}, almost_full, n >= AF);
    chk({tag, " almost_empty"}, almost_empty, n <= AE);
    chk({tag, " overflow"}, overflow, m_ovf);
    chk({tag, " underflow"}, underflow, m_udf);
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, " rvalid"}, rvalid, n != 0);
    if (n != 0) chk({tag, " rdata"}, rdata, mq[0]);
`else
    chk({tag, " rvalid"}, rvalid, m_rvalid);
    chk({tag, " rdata"}, rdata, m_rdata);
`endif
  endtask

  initial begin
    int c;
    bit fill_phase;

    // Vector table: fill 16, overflow write, drain 16, underflow read.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{we: 1'b1, re: 1'b0, clr: 1'b0, wdata: W'(i + 1), exp_count: i + 1,
                  exp_full: (i == 15), exp_empty: 1'b0, exp_af: (i + 1 >= AF), exp_ae: (i + 1 <= AE),
                  exp_ovf: 1'b0, exp_udf: 1'b0, exp_rvalid: 1'b0, chk_rd: 1'b1, exp_rd: '0};
    end
    vecs[16] = '{we: 1'b1, re: 1'b0, clr: 1'b0, wdata: 8'hFF, exp_count: 16,
                 exp_full: 1'b1, exp_empty: 1'b0, exp_af: 1'b1, exp_ae: 1'b0,
                 exp_ovf: 1'b1, exp_udf: 1'b0, exp_rvalid: 1'b0, chk_rd: 1'b1, exp_rd: '0};
    for (int j = 0; j < 16; j++) begin
      vecs[17 + j] = '{we: 1'b0, re: 1'b1, clr: 1'b0, wdata: '0, exp_count: 15 - j,
                       exp_full: 1'b0, exp_empty: (j == 15), exp_af: (15 - j >= AF), exp_ae: (15 - j <= AE),
                       exp_ovf: 1'b1, exp_udf: 1'b0, exp_rvalid: 1'b1, chk_rd: 1'b1, exp_rd: W'(j + 1)};
    end
    vecs[33] = '{we: 1'b0, re: 1'b1, clr: 1'b0, wdata: '0, exp_count: 0,
                 exp_full: 1'b0, exp_empty: 1'b1, exp_af: 1'b0, exp_ae: 1'b1,
                 exp_ovf: 1'b1, exp_udf: 1'b1, exp_rvalid: 1'b0, chk_rd: 1'b1, exp_rd: 8'h10};
`ifdef SYNC_FIFO_FWFT_EN
    for (int i = 0; i < 17; i++) begin
      vecs[i].exp_rvalid = 1'b1;
      vecs[i].exp_rd = 8'h01;
    end
    for (int j = 0; j < 16; j++) begin
      vecs[17 + j].exp_rvalid = (j < 15);
      vecs[17 + j].chk_rd = (j < 15);
      vecs[17 + j].exp_rd = W'(j + 2);
    end
    vecs[33].chk_rd = 1'b0;
`endif

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_model("reset");
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].we, vecs[i].re, vecs[i].clr, vecs[i].wdata);
      chk($sformatf("vec%0d count", i), count, vecs[i].exp_count);
      chk($sformatf("vec%0d full", i), full, vecs[i].exp_full);
      chk($sformatf("vec%0d empty", i), empty, vecs[i].exp_empty);
      chk($sformatf("vec%0d almost_full", i), almost_full, vecs[i].exp_af);
      chk($sformatf("vec%0d almost_empty", i), almost_empty, vecs[i].exp_ae);
      chk($sformatf("vec%0d overflow", i), overflow, vecs[i].exp_ovf);
      chk($sformatf("vec%0d underflow", i), underflow, vecs[i].exp_udf);
      chk($sformatf("vec%0d rvalid", i), rvalid, vecs[i].exp_rvalid);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rd);
    end

    // clr_err against a simultaneous underflow: the new error wins.
    apply(1'b0, 1'b1, 1'b1, '0);
    chk("clr_setwins overflow", overflow, 1'b0);
    chk("clr_setwins underflow", underflow, 1'b1);
    apply(1'b0, 1'b0, 1'b1, '0);
    check_model("clr_plain");

    // Steady state at 8 entries with simultaneous read and write across pointer wrap.
    for (int k = 0; k < 8; k++) apply(1'b1, 1'b0, 1'b0, W'(8'h20 + k));
    for (int k = 0; k < 20; k++) begin
      apply(1'b1, 1'b1, 1'b0, W'(8'h28 + k));
      chk("rw8 count", count, 8);
      check_model("rw8");
    end
    c = 0;
    while (mq.size() > 0 && c < 2 * D) begin
      apply(1'b0, 1'b1, 1'b0, '0);
      check_model("rw8_drain");
      c++;
    end
    apply(1'b0, 1'b0, 1'b0, '0);
    check_model("rw8_idle");

    // Full with read and write together: read wins, write is dropped, overflow set.
    for (int k = 0; k < D; k++) apply(1'b1, 1'b0, 1'b0, W'(8'h40 + k));
    check_model("full_fill");
    apply(1'b1, 1'b1, 1'b0, 8'hEE);
    chk("full_rw count", count, D - 1);
    chk("full_rw overflow", overflow, 1'b1);
    check_model("full_rw");
    c = 0;
    while (mq.size() > 0 && c < 2 * D) begin
      apply(1'b0, 1'b1, 1'b0, '0);
      check_model("full_drain");
`ifndef SYNC_FIFO_FWFT_EN
      chk("full_drain not_ee", rdata == 8'hEE, 1'b0);
`endif
      c++;
    end
    apply(1'b0, 1'b0, 1'b1, '0);
    check_model("full_clr");

    // Asynchronous reset asserted mid-cycle while writing.
    apply(1'b1, 1'b0, 1'b0, 8'hA5);
    we = 1'b1;
    wdata = 8'h77;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    #1;
    check_model("async_rst_hold");
    rst = 1'b1;
    we = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 8'h3C);
    check_model("post_rst_wr");
    apply(1'b0, 1'b1, 1'b0, '0);
    check_model("post_rst_rd");
`ifndef SYNC_FIFO_FWFT_EN
    chk("post_rst_rd data", rdata, 8'h3C);
    chk("post_rst_rd rvalid", rvalid, 1'b1);
`endif

    // Single word into an empty FIFO.
    apply(1'b1, 1'b0, 1'b0, 8'h5A);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_5a rdata", rdata, 8'h5A);
    chk("fwft_5a rvalid", rvalid, 1'b1);
`else
    chk("std_5a rvalid_before_re", rvalid, 1'b0);
`endif
    apply(1'b0, 1'b1, 1'b0, '0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("std_5a rdata", rdata, 8'h5A);
    chk("std_5a rvalid", rvalid, 1'b1);
    apply(1'b0, 1'b0, 1'b0, '0);
`endif
    chk("one_word rvalid_after", rvalid, 1'b0);
    chk("one_word empty_after", empty, 1'b1);
    check_model("one_word");

    // Random traffic with alternating fill/drain bias.
    for (int n = 0; n < 3000; n++) begin
      fill_phase = ((n / 150) % 2) == 0;
      apply($urandom_range(0, 99) < (fill_phase ? 75 : 30),
            $urandom_range(0, 99) < (fill_phase ? 30 : 75),
            $urandom_range(0, 99) < 3,
            W'($urandom));
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
